axis_m_pkt: RTL and testbench

Parametrised AXI-Stream packet master, the successor of the single-word axis_m.
- Buffers words written on a simple write port in an internal first-word-fall-through FIFO.
- On a send request, transmits a packet of a programmable number of beats over AXIS with full tready backpressure.
- Asserts tlast on the final beat only and pulses finish when the packet completes.
- Sits between a register/CPU-side producer and any AXIS slave in the infrastructure.

---
 rtl/axis_m_pkt.sv | 121 ++++++++++++
 tb/tb_axis_m_pkt.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_m_pkt.sv
// axis_m_pkt -- AXI-Stream packet master with a first-word-fall-through FIFO.
//
// Words written on the simple write port are buffered in the FIFO. A rising
// edge on send, while idle and with a non-zero pkt_len, starts a packet of
// pkt_len beats drawn from the FIFO head. tlast marks the final beat, and
// finish pulses for one cycle once the packet has completed.
//
// Ports
//   aclk, areset           clock, asynchronous active-high reset
//   wr_en, wr_data         FIFO write port
//   fifo_full, fifo_count  FIFO status
//   overflow               write dropped because the FIFO was full (same cycle)
//   send, pkt_len          packet request (rising edge), length in beats
//   busy, finish           packet in progress / one-cycle completion pulse
//   tvalid, tready, tdata, tlast   AXI-Stream master
module axis_m_pkt #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          send,
    input  logic [LEN_WIDTH-1:0]          pkt_len,
    output logic                          busy,
    input  logic                          tready,
    output logic                          tvalid,
    output logic [DATA_WIDTH-1:0]         tdata,
    output logic                          tlast,
    output logic                          finish
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 wr_acc, hs, empty;
    logic                 send_d, send_edge;
    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;

    // ---------------- FIFO ----------------
    assign empty      = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_count = count;
    assign wr_acc     = wr_en & ~fifo_full;
    // Drop decision uses the start-of-cycle count, so a same-cycle pop
    // does not rescue a write into a full FIFO.
    assign overflow   = wr_en & fifo_full;

    always_ff @(posedge aclk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (hs)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_acc) - CW'(hs);
        end
    end

    // ---------------- send edge detect ----------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) send_d <= 1'b0;
        else        send_d <= send;
    end
    assign send_edge = send & ~send_d;

    // ---------------- packet FSM ----------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (send_edge && pkt_len != '0) begin
                state_d = SEND;
                rem_d   = pkt_len;
            end
            SEND: if (hs) begin
                rem_d = rem_q - LEN_WIDTH'(1);
                if (rem_q == LEN_WIDTH'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tvalid comes from registers only; an empty FIFO mid-packet just
    // stalls, which is legal because tvalid only drops right after a pop.
    assign tvalid = (state_q == SEND) & ~empty;
    assign hs     = tvalid & tready;
    assign tlast  = tvalid & (rem_q == LEN_WIDTH'(1));
    // Head word is gated to zero when empty so outputs are clean after reset.
    assign tdata  = empty ? '0 : mem[rd_ptr];
    assign busy   = (state_q == SEND);
    assign finish = (state_q == DONE);

endmodule

// File: tb/tb_axis_m_pkt.sv
module tb_axis_m_pkt;
    localparam int DW = 32;
    localparam int FD = 16;
    localparam int LW = 8;

    logic                  aclk = 1'b0;
    logic                  areset = 1'b1;
    logic                  wr_en = 1'b0;
    logic [DW-1:0]         wr_data = '0;
    logic                  send = 1'b0;
    logic [LW-1:0]         pkt_len = '0;
    logic                  tready = 1'b0;
    logic                  fifo_full, overflow, busy, tvalid, tlast, finish;
    logic [$clog2(FD):0]   fifo_count;
    logic [DW-1:0]         tdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    axis_m_pkt #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)) dut (
        .aclk(aclk), .areset(areset), .wr_en(wr_en), .wr_data(wr_data),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow),
        .send(send), .pkt_len(pkt_len), .busy(busy), .tready(tready),
        .tvalid(tvalid), .tdata(tdata), .tlast(tlast), .finish(finish)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic start(input int len);
        pkt_len = LW'(len);
        send    = 1'b1;
        step();
        send    = 1'b0;
    endtask

    // Runs a packet already accepted. mc0 = words in FIFO at start.
    // mode 0: tready=1; 1: tready 1,0,0 repeating; 2: tready=1, one write
    // every 5 cycles; 3: tready=1 plus a second send edge mid-packet.
    task automatic run_pkt(input string tag, input int nb, input logic [DW-1:0] base,
                           input int mc0, input int mode);
        int  got = 0;
        int  mc  = mc0;
        int  wn  = 0;
        int  cyc = 0;
        bit  wrote, h, exp_tv;
        while (cyc < 300) begin
            tready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            wrote  = 1'b0;
            if (mode == 2 && cyc % 5 == 0 && wn < nb) begin
                wr_en = 1'b1; wr_data = base + DW'(wn); wn++; wrote = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            if (mode == 3) begin
                send = (cyc == 1);
                if (cyc == 1) pkt_len = LW'(5);
            end
            @(negedge aclk);
            exp_tv = (mc != 0) && (got < nb);
            chk({tag, " tvalid"}, tvalid, exp_tv);
            chk({tag, " busy"}, busy, got < nb);
            chk({tag, " finish"}, finish, got == nb);
            if (exp_tv) begin
                chk({tag, " tdata"}, tdata, base + DW'(got));
                chk({tag, " tlast"}, tlast, got == nb - 1);
            end
            if (got == nb) break;
            h = exp_tv && tready;
            if (h) got++;
            @(posedge aclk);
            #1;
            mc = mc + int'(wrote) - int'(h);
            cyc++;
        end
        chk({tag, " beats"}, got, nb);
        wr_en = 1'b0;
        send  = 1'b0;
        step();
    endtask

    initial begin
        // reset state
        @(negedge aclk);
        chk("rst tvalid", tvalid, 0);
        chk("rst busy", busy, 0);
        chk("rst finish", finish, 0);
        chk("rst tlast", tlast, 0);
        chk("rst count", fifo_count, 0);
        chk("rst full", fifo_full, 0);
        chk("rst overflow", overflow, 0);
        chk("rst tdata", tdata, 0);
        step();
        areset = 1'b0;

        // 1: basic 4-beat packet, tready=1
        for (int i = 0; i < 4; i++) wr(32'hA0 + DW'(i));
        @(negedge aclk);
        chk("t1 count", fifo_count, 4);
        step();
        start(4);
        run_pkt("t1", 4, 32'hA0, 4, 0);
        @(negedge aclk);
        chk("t1 count end", fifo_count, 0);
        step();

        // 2: same packet with tready toggling
        for (int i = 0; i < 4; i++) wr(32'hA0 + DW'(i));
        start(4);
        run_pkt("t2", 4, 32'hA0, 4, 1);

        // 3: send with FIFO empty, words trickle in
        start(3);
        run_pkt("t3", 3, 32'hB0, 0, 2);
        @(negedge aclk);
        chk("t3 count end", fifo_count, 0);
        step();

        // 4: fill, overflow, 16-beat packet
        for (int i = 0; i < 15; i++) wr(32'h100 + DW'(i));
        @(negedge aclk);
        chk("t4 full@15", fifo_full, 0);
        step();
        wr(32'h10F);
        wr_en = 1'b1;
        wr_data = 32'hDEAD;
        @(negedge aclk);
        chk("t4 full@16", fifo_full, 1);
        chk("t4 count16", fifo_count, 16);
        chk("t4 overflow", overflow, 1);
        step();
        wr_en = 1'b0;
        @(negedge aclk);
        chk("t4 overflow clr", overflow, 0);
        chk("t4 count kept", fifo_count, 16);
        step();
        start(16);
        run_pkt("t4", 16, 32'h100, 16, 0);

        // 5: pkt_len=0 ignored, mid-packet send ignored, leftovers kept
        for (int i = 0; i < 6; i++) wr(32'hC0 + DW'(i));
        start(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("t5 len0 busy", busy, 0);
            chk("t5 len0 tvalid", tvalid, 0);
            chk("t5 len0 finish", finish, 0);
            step();
        end
        start(4);
        run_pkt("t5", 4, 32'hC0, 6, 3);
        @(negedge aclk);
        chk("t5 leftover", fifo_count, 2);
        chk("t5 idle", busy, 0);
        step();
        start(2);
        run_pkt("t5b", 2, 32'hC4, 2, 0);

        // 6: reset during beat 2 of 5
        for (int i = 0; i < 5; i++) wr(32'hE0 + DW'(i));
        tready = 1'b1;
        start(5);
        @(negedge aclk);
        chk("t6 beat1", tdata, 32'hE0);
        step();
        @(negedge aclk);
        chk("t6 beat2", tdata, 32'hE1);
        areset = 1'b1;
        #1;
        chk("t6 rst tvalid", tvalid, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst count", fifo_count, 0);
        chk("t6 rst finish", finish, 0);
        step();
        areset = 1'b0;
        @(negedge aclk);
        chk("t6 no finish", finish, 0);
        step();
        wr(32'hF0);
        wr(32'hF1);
        start(2);
        run_pkt("t6b", 2, 32'hF0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
